// File: rtl/unidade_controle_if.sv
// Control-unit bus: instruction fetch handshake on one side,
// register-bank / ALU control on the other.
interface unidade_controle_if #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2,
  parameter int largura_pc    = 8
);
  logic [bits_palavra-1:0]  Instrucao;
  logic                     Inst_Valida;
  logic                     Flag_Zero;
  logic                     Inst_Pronta;
  logic [largura_pc-1:0]    PC;
  logic [end_registros-1:0] Sel_SA;
  logic [end_registros-1:0] Sel_SB;
  logic [end_registros-1:0] Sel_SC;
  logic                     Hab_Escrita;
  logic [2:0]               Op_ULA;
  logic                     Sel_Imediato;
  logic [bits_palavra-1:0]  Imediato;
  logic                     Parado;
  logic                     Erro_Opcode;

  modport master (
    input  Instrucao, Inst_Valida, Flag_Zero,
    output Inst_Pronta, PC, Sel_SA, Sel_SB, Sel_SC, Hab_Escrita,
           Op_ULA, Sel_Imediato, Imediato, Parado, Erro_Opcode
  );

  modport slave (
    output Instrucao, Inst_Valida, Flag_Zero,
    input  Inst_Pronta, PC, Sel_SA, Sel_SB, Sel_SC, Hab_Escrita,
           Op_ULA, Sel_Imediato, Imediato, Parado, Erro_Opcode
  );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetch / decode / execute / write-back FSM
// driving register-bank addresses, ALU op, immediate and the program counter.
module unidade_controle #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2,
  parameter int largura_pc    = 8
) (
  input  logic               clock,
  input  logic               reset,
  unidade_controle_if.master bus
);
  typedef enum logic [2:0] {BUSCA, DECODIFICA, EXECUTA, ESCRITA, PARADO} estado_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LI   = 4'h5;
  localparam logic [3:0] OP_BEQZ = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  estado_t                  estado_reg;
  logic [bits_palavra-1:0]  ir_reg;
  logic [largura_pc-1:0]    pc_reg;
  logic [end_registros-1:0] sel_sa_reg, sel_sb_reg, sel_sc_reg;
  logic [2:0]               op_ula_reg;
  logic                     sel_imediato_reg;
  logic [bits_palavra-1:0]  imediato_reg;
  logic                     hab_escrita_reg, parado_reg, erro_opcode_reg, inst_pronta_reg;

  logic [3:0]            opcode;
  logic [largura_pc-1:0] pc_inc, pc_desvio;

  assign opcode    = ir_reg[15:12];
  assign pc_inc    = pc_reg + largura_pc'(1);
  // Branch offset is relative to the instruction after the branch.
  assign pc_desvio = pc_inc + largura_pc'($signed(ir_reg[7:0]));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg       <= BUSCA;
      ir_reg           <= '0;
      pc_reg           <= '0;
      sel_sa_reg       <= '0;
      sel_sb_reg       <= '0;
      sel_sc_reg       <= '0;
      op_ula_reg       <= 3'd0;
      sel_imediato_reg <= 1'b0;
      imediato_reg     <= '0;
      hab_escrita_reg  <= 1'b0;
      parado_reg       <= 1'b0;
      erro_opcode_reg  <= 1'b0;
      inst_pronta_reg  <= 1'b1;
    end else begin
      unique case (estado_reg)
        BUSCA: begin
          if (bus.Inst_Valida) begin
            ir_reg          <= bus.Instrucao;
            // Addresses are loaded straight from the incoming word so they are valid during DECODIFICA.
            sel_sc_reg      <= end_registros'(bus.Instrucao[11:10]);
            sel_sa_reg      <= end_registros'(bus.Instrucao[9:8]);
            sel_sb_reg      <= end_registros'(bus.Instrucao[7:6]);
            inst_pronta_reg <= 1'b0;
            estado_reg      <= DECODIFICA;
          end
        end
        DECODIFICA: begin
          imediato_reg     <= bits_palavra'($signed(ir_reg[7:0]));
          sel_imediato_reg <= (opcode == OP_LI);
          erro_opcode_reg  <= (opcode >= 4'h8) && (opcode <= 4'hE);
          unique case (opcode)
            OP_ADD:  op_ula_reg <= 3'd1;
            OP_SUB:  op_ula_reg <= 3'd2;
            OP_AND:  op_ula_reg <= 3'd3;
            OP_OR:   op_ula_reg <= 3'd4;
            default: op_ula_reg <= 3'd0;
          endcase
          estado_reg <= EXECUTA;
        end
        EXECUTA: begin
          erro_opcode_reg <= 1'b0;
          unique case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LI: begin
              hab_escrita_reg <= 1'b1;
              estado_reg      <= ESCRITA;
            end
            OP_HALT: begin
              parado_reg <= 1'b1;
              estado_reg <= PARADO;
            end
            OP_BEQZ: begin
              pc_reg          <= bus.Flag_Zero ? pc_desvio : pc_inc;
              inst_pronta_reg <= 1'b1;
              estado_reg      <= BUSCA;
            end
            OP_JMP: begin
              pc_reg          <= pc_desvio;
              inst_pronta_reg <= 1'b1;
              estado_reg      <= BUSCA;
            end
            default: begin
              pc_reg          <= pc_inc;
              inst_pronta_reg <= 1'b1;
              estado_reg      <= BUSCA;
            end
          endcase
        end
        ESCRITA: begin
          hab_escrita_reg <= 1'b0;
          pc_reg          <= pc_inc;
          inst_pronta_reg <= 1'b1;
          estado_reg      <= BUSCA;
        end
        PARADO: begin
          estado_reg <= PARADO;
        end
        default: begin
          inst_pronta_reg <= 1'b1;
          estado_reg      <= BUSCA;
        end
      endcase
    end
  end

  assign bus.Inst_Pronta  = inst_pronta_reg;
  assign bus.PC           = pc_reg;
  assign bus.Sel_SA       = sel_sa_reg;
  assign bus.Sel_SB       = sel_sb_reg;
  assign bus.Sel_SC       = sel_sc_reg;
  assign bus.Hab_Escrita  = hab_escrita_reg;
  assign bus.Op_ULA       = op_ula_reg;
  assign bus.Sel_Imediato = sel_imediato_reg;
  assign bus.Imediato     = imediato_reg;
  assign bus.Parado       = parado_reg;
  assign bus.Erro_Opcode  = erro_opcode_reg;
endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: expected per-instruction results are
// queued when an instruction is offered and checked as the FSM walks through it.
module tb_unidade_controle;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  unidade_controle_if bus ();

  unidade_controle dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [1:0]  sa, sb, sc;
    logic [2:0]  op;
    logic        simm;
    logic [15:0] imm;
    logic        err;
    logic        wr;
    logic        halt;
    logic [7:0]  next_pc;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] pc_model = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] instr, input logic [7:0] pc, input logic fz);
    exp_t e;
    logic [7:0] off;
    off       = instr[7:0];
    e.sc      = instr[11:10];
    e.sa      = instr[9:8];
    e.sb      = instr[7:6];
    e.imm     = {{8{instr[7]}}, instr[7:0]};
    e.op      = 3'd0;
    e.simm    = 1'b0;
    e.err     = 1'b0;
    e.wr      = 1'b0;
    e.halt    = 1'b0;
    e.next_pc = pc + 8'd1;
    case (instr[15:12])
      4'h1: begin e.op = 3'd1; e.wr = 1'b1; end
      4'h2: begin e.op = 3'd2; e.wr = 1'b1; end
      4'h3: begin e.op = 3'd3; e.wr = 1'b1; end
      4'h4: begin e.op = 3'd4; e.wr = 1'b1; end
      4'h5: begin e.simm = 1'b1; e.wr = 1'b1; end
      4'h6: if (fz) e.next_pc = pc + 8'd1 + off;
      4'h7: e.next_pc = pc + 8'd1 + off;
      4'hF: begin e.halt = 1'b1; e.next_pc = pc; end
      4'h0: ;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},     32'(bus.PC), 32'h0);
    check({tag, "_sa"},     32'(bus.Sel_SA), 32'h0);
    check({tag, "_sb"},     32'(bus.Sel_SB), 32'h0);
    check({tag, "_sc"},     32'(bus.Sel_SC), 32'h0);
    check({tag, "_op"},     32'(bus.Op_ULA), 32'h0);
    check({tag, "_imm"},    32'(bus.Imediato), 32'h0);
    check({tag, "_simm"},   32'(bus.Sel_Imediato), 32'h0);
    check({tag, "_hab"},    32'(bus.Hab_Escrita), 32'h0);
    check({tag, "_parado"}, 32'(bus.Parado), 32'h0);
    check({tag, "_erro"},   32'(bus.Erro_Opcode), 32'h0);
    check({tag, "_pronta"}, 32'(bus.Inst_Pronta), 32'h1);
  endtask

  // Offers one instruction and follows it to completion; abort asserts reset mid-ESCRITA.
  task automatic issue(input logic [15:0] instr, input logic fz, input logic abort);
    exp_t e;
    logic [7:0] pc_start;
    pc_start = pc_model;
    sb_q.push_back(model(instr, pc_model, fz));
    check("fetch_pronta", 32'(bus.Inst_Pronta), 32'h1);
    check("fetch_pc", 32'(bus.PC), 32'(pc_start));
    bus.Instrucao   = instr;
    bus.Inst_Valida = 1'b1;
    bus.Flag_Zero   = fz;
    @(posedge clock); #1;
    bus.Inst_Valida = 1'b0;
    bus.Instrucao   = 16'($urandom);
    e = sb_q.pop_front();
    check("dec_pronta", 32'(bus.Inst_Pronta), 32'h0);
    check("dec_sa", 32'(bus.Sel_SA), 32'(e.sa));
    check("dec_sb", 32'(bus.Sel_SB), 32'(e.sb));
    check("dec_sc", 32'(bus.Sel_SC), 32'(e.sc));
    check("dec_hab", 32'(bus.Hab_Escrita), 32'h0);
    @(posedge clock); #1;
    check("exe_op", 32'(bus.Op_ULA), 32'(e.op));
    check("exe_simm", 32'(bus.Sel_Imediato), 32'(e.simm));
    check("exe_imm", 32'(bus.Imediato), 32'(e.imm));
    check("exe_erro", 32'(bus.Erro_Opcode), 32'(e.err));
    check("exe_hab", 32'(bus.Hab_Escrita), 32'h0);
    check("exe_pronta", 32'(bus.Inst_Pronta), 32'h0);
    @(posedge clock); #1;
    check("post_erro", 32'(bus.Erro_Opcode), 32'h0);
    if (e.halt) begin
      check("halt_parado", 32'(bus.Parado), 32'h1);
      check("halt_pronta", 32'(bus.Inst_Pronta), 32'h0);
      check("halt_pc", 32'(bus.PC), 32'(e.next_pc));
    end else if (e.wr) begin
      check("wb_hab", 32'(bus.Hab_Escrita), 32'h1);
      check("wb_sc", 32'(bus.Sel_SC), 32'(e.sc));
      check("wb_pronta", 32'(bus.Inst_Pronta), 32'h0);
      if (abort) begin
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        e.next_pc = 8'h00;
        @(posedge clock); #1;
        reset = 1'b0;
      end else begin
        @(posedge clock); #1;
        check("wb_done_hab", 32'(bus.Hab_Escrita), 32'h0);
        check("wb_done_pronta", 32'(bus.Inst_Pronta), 32'h1);
        check("wb_done_pc", 32'(bus.PC), 32'(e.next_pc));
      end
    end else begin
      check("nw_hab", 32'(bus.Hab_Escrita), 32'h0);
      check("nw_pronta", 32'(bus.Inst_Pronta), 32'h1);
      check("nw_pc", 32'(bus.PC), 32'(e.next_pc));
    end
    pc_model = e.next_pc;
    $display("txn pc=%02h instr=%04h fz=%0b next_pc=%02h checks=%0d", pc_start, instr, fz, e.next_pc, checks);
  endtask

  initial begin
    bus.Instrucao   = 16'h0000;
    bus.Inst_Valida = 1'b0;
    bus.Flag_Zero   = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(posedge clock); #1;
    reset = 1'b0;

    issue(16'h1640, 1'b0, 1'b0);   // ADD r1 <- r2 + r1 at PC 0
    issue(16'h58F0, 1'b0, 1'b0);   // LI r2 <- 0xFFF0
    issue(16'h2E40, 1'b1, 1'b0);   // SUB
    issue(16'h3000, 1'b0, 1'b0);   // AND, writes r0
    issue(16'h0000, 1'b0, 1'b0);   // NOP at PC 4
    issue(16'h60FE, 1'b1, 1'b0);   // BEQZ taken at PC 5 -> 4
    issue(16'h0000, 1'b0, 1'b0);   // NOP at 4 -> 5
    issue(16'h60FE, 1'b0, 1'b0);   // BEQZ not taken at 5 -> 6
    issue(16'h70F8, 1'b0, 1'b0);   // JMP -8 from 6 -> 0xFF

    bus.Inst_Valida = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("idle_pronta", 32'(bus.Inst_Pronta), 32'h1);
      check("idle_pc", 32'(bus.PC), 32'h0FF);
    end
    $display("txn idle 10 cycles pc=%02h", pc_model);

    issue(16'h0000, 1'b0, 1'b0);   // NOP at 0xFF wraps to 0x00
    issue(16'h9ABC, 1'b0, 1'b0);   // undefined opcode
    issue(16'h4D80, 1'b0, 1'b1);   // OR, reset asserted during ESCRITA
    issue(16'h58F0, 1'b0, 1'b0);   // LI accepted on first edge after reset
    issue(16'hF000, 1'b0, 1'b0);   // HALT at PC 1

    for (int i = 0; i < 15; i++) begin
      bus.Inst_Valida = i[0];
      bus.Instrucao   = 16'h1640;
      @(posedge clock); #1;
      check("halted_parado", 32'(bus.Parado), 32'h1);
      check("halted_pronta", 32'(bus.Inst_Pronta), 32'h0);
      check("halted_pc", 32'(bus.PC), 32'h01);
      check("halted_hab", 32'(bus.Hab_Escrita), 32'h0);
    end
    bus.Inst_Valida = 1'b0;
    $display("txn halted 15 cycles pc=%02h", pc_model);

    reset = 1'b1;
    #1;
    check_reset_outputs("rst2");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("after_rst_pronta", 32'(bus.Inst_Pronta), 32'h1);
    check("after_rst_pc", 32'(bus.PC), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have parameter bits_palavra, default 16, giving the instruction and immediate word width.
REQ-002 The block SHALL have parameter end_registros, default 2, giving the register-address width driven to the register bank.
REQ-003 The block SHALL have parameter largura_pc, default 8, giving the program counter width.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port Instrucao, input, bits_palavra bits: instruction word from instruction memory.
REQ-007 The block SHALL have port Inst_Valida, input, 1 bit: Instrucao is valid this cycle.
REQ-008 The block SHALL have port Flag_Zero, input, 1 bit: ALU zero flag.
REQ-009 The block SHALL have port Inst_Pronta, output, 1 bit: ready to accept an instruction.
REQ-010 The block SHALL have port PC, output, largura_pc bits: instruction address.
REQ-011 The block SHALL have ports Sel_SA and Sel_SB, output, end_registros bits each: register-bank read addresses.
REQ-012 The block SHALL have port Sel_SC, output, end_registros bits: register-bank write address.
REQ-013 The block SHALL have port Hab_Escrita, output, 1 bit: register-bank write enable.
REQ-014 The block SHALL have port Op_ULA, output, 3 bits: ALU operation (0 pass-B, 1 add, 2 sub, 3 and, 4 or).
REQ-015 The block SHALL have port Sel_Imediato, output, 1 bit: selects Imediato instead of bank output B.
REQ-016 The block SHALL have port Imediato, output, bits_palavra bits: sign-extended Instrucao[7:0].
REQ-017 The block SHALL have port Parado, output, 1 bit: processor halted.
REQ-018 The block SHALL have port Erro_Opcode, output, 1 bit: one-cycle pulse on an undefined opcode.

Function
REQ-019 Instruction fields SHALL be: opcode [15:12], rd [11:10], ra [9:8], rb [7:6], imm8 [7:0].
REQ-020 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LI (rd <= sext(imm8)), 6 BEQZ, 7 JMP, 15 HALT; 8-14 undefined.
REQ-021 The FSM SHALL have the states BUSCA, DECODIFICA, EXECUTA, ESCRITA and PARADO.
REQ-022 In BUSCA, Inst_Pronta SHALL be 1; when Inst_Valida=1, Instrucao SHALL be latched into the internal IR and the next state SHALL be DECODIFICA; otherwise the FSM SHALL stay in BUSCA.
REQ-023 In every state other than BUSCA, Inst_Pronta SHALL be 0 and Inst_Valida SHALL be ignored.
REQ-024 From DECODIFICA onward, Sel_SA=ra, Sel_SB=rb and Sel_SC=rd SHALL be driven from IR and held until the next BUSCA.
REQ-025 DECODIFICA SHALL last one cycle and always go to EXECUTA.
REQ-026 In EXECUTA, Op_ULA, Sel_Imediato and Imediato SHALL be valid; LI SHALL drive Op_ULA=0 with Sel_Imediato=1.
REQ-027 ADD/SUB/AND/OR/LI SHALL go from EXECUTA to ESCRITA; NOP/BEQZ/JMP/undefined SHALL go from EXECUTA to BUSCA; HALT SHALL go from EXECUTA to PARADO.
REQ-028 ESCRITA SHALL assert Hab_Escrita for exactly one cycle, then go to BUSCA; Hab_Escrita SHALL be 0 in all other states.
REQ-029 Writes to any rd, including register 0, SHALL be permitted.
REQ-030 On leaving EXECUTA (non-branch) or ESCRITA, PC SHALL become PC+1 modulo 2^largura_pc; 0xFF SHALL wrap to 0x00.
REQ-031 For JMP, or BEQZ with Flag_Zero=1 sampled in EXECUTA, PC SHALL become PC+1+sext(imm8) modulo 2^largura_pc; BEQZ with Flag_Zero=0 SHALL give PC+1.
REQ-032 For undefined opcodes, Erro_Opcode SHALL pulse for the single EXECUTA cycle, with no register write and PC+1.
REQ-033 In PARADO, Parado SHALL be 1, PC SHALL be frozen, and the FSM SHALL leave PARADO only on reset.
REQ-034 Latency from instruction acceptance to the Hab_Escrita pulse SHALL be 3 cycles (DECODIFICA, EXECUTA, ESCRITA).

Reset
REQ-035 While reset=1, the FSM SHALL be held in BUSCA.
REQ-036 While reset=1, PC, IR, Sel_SA, Sel_SB, Sel_SC, Op_ULA, Imediato, Sel_Imediato, Hab_Escrita, Parado and Erro_Opcode SHALL all be 0 and Inst_Pronta SHALL be 1.
REQ-037 A reset asserted mid-ESCRITA SHALL drop Hab_Escrita immediately, without waiting for a clock edge.
REQ-038 A reset SHALL abort any in-flight instruction; fetch SHALL resume at PC=0 on the first edge after reset is released.

Verification
REQ-039 The bench SHALL cover: ADD 0x1640 (rd=1, ra=2, rb=1) accepted at PC=0 -> Op_ULA=1, Sel_SA=2, Sel_SB=1; Hab_Escrita=1 with Sel_SC=1 3 cycles after acceptance; PC=1.
REQ-040 The bench SHALL cover: LI 0x58F0 -> Imediato=0xFFF0, Sel_Imediato=1, Sel_SC=2, one Hab_Escrita pulse.
REQ-041 The bench SHALL cover: BEQZ 0x60FE at PC=5 with Flag_Zero=1 -> PC=4 and no write; with Flag_Zero=0 -> PC=6.
REQ-042 The bench SHALL cover: Inst_Valida held low for 10 cycles -> FSM stays in BUSCA, PC unchanged; then NOP at PC=0xFF -> PC=0x00.
REQ-043 The bench SHALL cover: opcode 0x9 -> one-cycle Erro_Opcode pulse, no write; HALT 0xF000 -> Parado=1 and Inst_Pronta=0 indefinitely until reset.
REQ-044 The bench SHALL cover: reset asserted during ESCRITA -> Hab_Escrita=0 before the next edge, PC=0, fetch restarts at PC=0.
